// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and constants for the ID-stage scoreboard.
//   - reg_idx_t  : 5-bit architectural register index
//   - REG_ZERO   : index of the hard-wired zero register (never tracked)
//   - DEF_CNT_W  : default per-register in-flight counter width
//   - CNT_MAX    : saturation value of a DEF_CNT_W-wide counter
//   - cnt_max()  : saturation value for an arbitrary counter width
// -----------------------------------------------------------------------------
package pipeline_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO  = 5'd0;
    localparam int       DEF_CNT_W = 2;

    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int CNT_MAX = (1 << DEF_CNT_W) - 1;

endpackage

// File: rtl/scoreboard_entry.sv
// -----------------------------------------------------------------------------
// scoreboard_entry
//   Tracking state for one architectural register: the number of writes in
//   flight (cnt) and whether the youngest of them is a load whose data is not
//   yet past MEM (late).
//
// Ports:
//   clk, reset    in   clock, synchronous active-high reset
//   inc           in   a writer of this register issues this cycle
//   inc_is_load   in   that writer is a load
//   mem_clr       in   a load to this register reached MEM/WB this cycle
//   dec           in   a write to this register retires this cycle
//   cnt           out  in-flight write count
//   late          out  youngest writer's result cannot be forwarded yet
//   underflow     out  retire seen while cnt is zero
// -----------------------------------------------------------------------------
module scoreboard_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             inc_is_load,
    input  logic             mem_clr,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             late,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             late_d, late_q;
    logic             dec_ok;

    // A retire against an empty counter is an error, not a decrement.
    assign dec_ok = dec && (cnt_q != '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        cnt_d  = cnt_q;
        late_d = late_q;

        // Issue and retire in the same cycle cancel out.
        if (inc && !dec_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!inc && dec_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // The newest writer owns the flag, so issue beats a mem_done clear.
        if (inc) begin
            late_d = inc_is_load;
        end else if (mem_clr) begin
            late_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        // NOTE: the per-register state is reset (not left to power-up value)
        // because idle/pending and the stall decision read it directly.
        if (reset) begin
            cnt_q  <= '0;
            late_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            late_q <= late_d;
        end
    end

    assign cnt       = cnt_q;
    assign late      = late_q;
    assign underflow = dec && (cnt_q == '0);

endmodule

// File: rtl/scoreboard_unit.sv
// -----------------------------------------------------------------------------
// scoreboard_unit
//   ID-stage write scoreboard. Tracks every in-flight register write from
//   issue until writeback and stalls issue when a source can't be bypassed
//   yet (load result not past MEM) or a destination counter is saturated.
//
// Optional build macro: SCOREBOARD_STATS_EN adds saturating 32-bit counters
//   stall_cycles and load_use_stalls as extra output ports.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   issue_valid, issue_reg_write,
//   issue_is_load, issue_rd         instruction trying to leave ID
//   rs1, rs2, rs1_used, rs2_used    its source operands
//   mem_done_valid, mem_done_rd     load result reached MEM/WB
//   wb_valid, wb_rd                 register write retiring
//   stall, issue_fire               combinational issue control
//   pending                         per-register "writes in flight"
//   idle                            nothing in flight
//   err                             sticky: retire with no write in flight
//   stall_cycles, load_use_stalls   (SCOREBOARD_STATS_EN only)
// -----------------------------------------------------------------------------
module scoreboard_unit
    import pipeline_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_reg_write,
    input  logic             issue_is_load,
    input  logic [4:0]       issue_rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic             mem_done_valid,
    input  logic [4:0]       mem_done_rd,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             stall,
    output logic             issue_fire,
    output logic [NREGS-1:0] pending,
    output logic             idle,
    output logic             err
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      load_use_stalls
`endif
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(cnt_max(CNT_W));

    logic [NREGS-1:0][CNT_W-1:0] cnt_vec;
    logic [NREGS-1:0]            late_vec;
    logic [NREGS-1:0]            underflow_vec;

    logic hazard1, hazard2, full, load_use;
    logic issue_wr_en;
    logic err_d, err_q;

    // x0 carries no state.
    assign cnt_vec[0]       = '0;
    assign late_vec[0]      = 1'b0;
    assign underflow_vec[0] = 1'b0;

    assign issue_wr_en = issue_fire && issue_reg_write && (issue_rd != REG_ZERO);

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        scoreboard_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk         (clk),
            .reset       (reset),
            .inc         (issue_wr_en && (issue_rd == reg_idx_t'(r))),
            .inc_is_load (issue_is_load),
            .mem_clr     (mem_done_valid && (mem_done_rd == reg_idx_t'(r))),
            .dec         (wb_valid && (wb_rd == reg_idx_t'(r))),
            .cnt         (cnt_vec[r]),
            .late        (late_vec[r]),
            .underflow   (underflow_vec[r])
        );
    end

    // Stall looks only at registered state: mem_done is not bypassed, so a
    // load-use pair releases the cycle after the load leaves MEM.
    assign hazard1  = rs1_used && (rs1 != REG_ZERO) && late_vec[rs1];
    assign hazard2  = rs2_used && (rs2 != REG_ZERO) && late_vec[rs2];
    assign full     = issue_reg_write && (issue_rd != REG_ZERO) &&
                      (cnt_vec[issue_rd] == FULL_CNT);
    assign load_use = issue_valid && (hazard1 || hazard2);

    assign stall      = issue_valid && (hazard1 || hazard2 || full);
    assign issue_fire = issue_valid && !stall;

    always_comb begin
        pending = '0;
        for (int r = 1; r < NREGS; r++) begin
            pending[r] = |cnt_vec[r];
        end
    end

    assign idle = ~|pending;

    assign err_d = err_q || (|underflow_vec);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_d, stall_cycles_q;
    logic [31:0] load_use_stalls_d, load_use_stalls_q;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cycles_d    = stall_cycles_q;
        load_use_stalls_d = load_use_stalls_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (load_use && (load_use_stalls_q != 32'hFFFF_FFFF)) begin
            load_use_stalls_d = load_use_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q    <= '0;
            load_use_stalls_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_d;
            load_use_stalls_q <= load_use_stalls_d;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign load_use_stalls = load_use_stalls_q;
`endif

endmodule

// File: tb/tb_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_unit
//   Directed bench for scoreboard_unit. Inputs change 1 time unit after the
//   rising edge; outputs are sampled before the next rising edge.
// -----------------------------------------------------------------------------
module tb_scoreboard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_reg_write, issue_is_load;
    logic [4:0]  issue_rd, rs1, rs2, mem_done_rd, wb_rd;
    logic        rs1_used, rs2_used, mem_done_valid, wb_valid;
    logic        stall, issue_fire, idle, err;
    logic [31:0] pending;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles, load_use_stalls;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    scoreboard_unit dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_reg_write (issue_reg_write),
        .issue_is_load   (issue_is_load),
        .issue_rd        (issue_rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .rs1_used        (rs1_used),
        .rs2_used        (rs2_used),
        .mem_done_valid  (mem_done_valid),
        .mem_done_rd     (mem_done_rd),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .stall           (stall),
        .issue_fire      (issue_fire),
        .pending         (pending),
        .idle            (idle),
        .err             (err)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .load_use_stalls (load_use_stalls)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        issue_valid     = 1'b0;
        issue_reg_write = 1'b0;
        issue_is_load   = 1'b0;
        issue_rd        = 5'd0;
        rs1             = 5'd0;
        rs2             = 5'd0;
        rs1_used        = 1'b0;
        rs2_used        = 1'b0;
        mem_done_valid  = 1'b0;
        mem_done_rd     = 5'd0;
        wb_valid        = 1'b0;
        wb_rd           = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic is_load);
        clear_inputs();
        issue_valid     = 1'b1;
        issue_reg_write = 1'b1;
        issue_is_load   = is_load;
        issue_rd        = rd;
    endtask

    task automatic do_wb(input logic [4:0] rd);
        clear_inputs();
        wb_valid = 1'b1;
        wb_rd    = rd;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_inputs();
        settle();
    endtask

    initial begin
        clear_inputs();
        // Reset with an issue request present; it must be ignored.
        reset           = 1'b1;
        issue_valid     = 1'b1;
        issue_reg_write = 1'b1;
        issue_rd        = 5'd4;
        tick();
        tick();
        reset = 1'b0;
        clear_inputs();
        settle();
        check("reset_pending", pending, 32'h0);
        check("reset_idle", {31'd0, idle}, 32'd1);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        // ALU write to x5, forwardable consumer, writeback.
        do_issue(5'd5, 1'b0);
        settle();
        check("add_x5_fire", {31'd0, issue_fire}, 32'd1);
        tick();
        check("add_x5_pending", pending, 32'h0000_0020);
        check("add_x5_not_idle", {31'd0, idle}, 32'd0);
        clear_inputs();
        issue_valid = 1'b1;
        rs1         = 5'd5;
        rs1_used    = 1'b1;
        settle();
        check("x5_consumer_no_stall", {31'd0, stall}, 32'd0);
        tick();
        check("nowrite_issue_keeps", pending, 32'h0000_0020);
        do_wb(5'd5);
        tick();
        clear_inputs();
        settle();
        check("wb_x5_pending", pending, 32'h0);
        check("wb_x5_idle", {31'd0, idle}, 32'd1);

        // Load-use on x7 through rs2.
        do_issue(5'd7, 1'b1);
        tick();
        clear_inputs();
        issue_valid = 1'b1;
        rs2         = 5'd7;
        rs2_used    = 1'b1;
        settle();
        check("lw_use_stall", {31'd0, stall}, 32'd1);
        check("lw_use_no_fire", {31'd0, issue_fire}, 32'd0);
        tick();
        mem_done_valid = 1'b1;
        mem_done_rd    = 5'd7;
        settle();
        check("mem_done_cycle_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_done_valid = 1'b0;
        settle();
        check("after_mem_done_stall", {31'd0, stall}, 32'd0);
        check("after_mem_done_fire", {31'd0, issue_fire}, 32'd1);
        tick();

        // Same hazard with the sources unused; then a load to x0.
        do_issue(5'd7, 1'b1);
        tick();
        clear_inputs();
        issue_valid = 1'b1;
        rs1         = 5'd7;
        rs2         = 5'd7;
        settle();
        check("unused_src_no_stall", {31'd0, stall}, 32'd0);
        tick();
        do_issue(5'd0, 1'b1);
        settle();
        check("lw_x0_fire", {31'd0, issue_fire}, 32'd1);
        tick();
        check("x0_never_pending", pending, 32'h0000_0080);
        clear_inputs();
        issue_valid = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        settle();
        check("x0_src_no_stall", {31'd0, stall}, 32'd0);
        tick();
        do_wb(5'd7);
        mem_done_valid = 1'b1;
        mem_done_rd    = 5'd7;
        tick();
        do_wb(5'd7);
        tick();
        clear_inputs();
        settle();
        check("x7_drained_idle", {31'd0, idle}, 32'd1);

        // Counter saturation on x3.
        for (int i = 0; i < 3; i++) begin
            do_issue(5'd3, 1'b0);
            tick();
        end
        do_issue(5'd3, 1'b0);
        settle();
        check("x3_full_stall", {31'd0, stall}, 32'd1);
        tick();
        check("x3_full_still_stall", {31'd0, stall}, 32'd1);
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        settle();
        check("x3_full_wb_same_cycle", {31'd0, stall}, 32'd1);
        tick();
        // cnt now 2: issue together with a retire keeps it at 2.
        wb_valid = 1'b0;
        settle();
        check("x3_after_wb_no_stall", {31'd0, stall}, 32'd0);
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        settle();
        check("x3_cnt2_no_stall", {31'd0, stall}, 32'd0);
        tick();
        settle();
        check("x3_cnt3_stall", {31'd0, stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            do_wb(5'd3);
            tick();
        end
        clear_inputs();
        settle();
        check("x3_drained_idle", {31'd0, idle}, 32'd1);
        check("x3_no_err", {31'd0, err}, 32'd0);

        // Underflow error is sticky until reset.
        do_wb(5'd9);
        tick();
        clear_inputs();
        settle();
        check("wb_x9_err", {31'd0, err}, 32'd1);
        check("wb_x9_pending", pending, 32'h0);
        do_issue(5'd11, 1'b1);
        tick();
        clear_inputs();
        settle();
        check("err_sticky", {31'd0, err}, 32'd1);
        reset           = 1'b1;
        issue_valid     = 1'b1;
        issue_reg_write = 1'b1;
        issue_rd        = 5'd4;
        tick();
        check("mid_reset_err", {31'd0, err}, 32'd0);
        check("mid_reset_pending", pending, 32'h0);
        reset = 1'b0;
        clear_inputs();
        settle();
        check("mid_reset_idle", {31'd0, idle}, 32'd1);

`ifdef SCOREBOARD_STATS_EN
        apply_reset();
        check("stats_reset_stall", stall_cycles, 32'd0);
        check("stats_reset_lu", load_use_stalls, 32'd0);
        do_issue(5'd7, 1'b1);
        tick();
        clear_inputs();
        issue_valid = 1'b1;
        rs1         = 5'd7;
        rs1_used    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        clear_inputs();
        mem_done_valid = 1'b1;
        mem_done_rd    = 5'd7;
        tick();
        for (int i = 0; i < 3; i++) begin
            do_issue(5'd3, 1'b0);
            tick();
        end
        do_issue(5'd3, 1'b0);
        tick();
        tick();
        clear_inputs();
        settle();
        check("stats_stall_cycles", stall_cycles, 32'd6);
        check("stats_load_use", load_use_stalls, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
